// File: rtl/lutram_array_bist.sv
// lutram_array_bist
//   Banked LUTRAM word array built from 16x10 distributed-RAM primitives. Each
//   bank is 16 rows deep; a word spans ceil(DATA_W/10) primitives. Reads are
//   registered and qualified by a one-cycle rvalid. Out-of-range addresses
//   drop writes and read as zero.
//   Optional March C- self-test, compiled in only when LUTRAM_BIST_EN is
//   defined. Without it the bist_* outputs are tied to 0.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   addr/we/wdat      write port: addr[3:0] = row, upper bits = bank
//   addr/re           read request; rdat/rvalid appear one cycle later
//   bist_start        start self-test (sampled when idle or done)
//   bist_busy         self-test running (user port blocked)
//   bist_done         self-test finished, held until next start or reset
//   bist_pass         no mismatch in last run (valid with bist_done)
//   bist_fail_addr    address of first mismatch

module lutram_16x10 (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [9:0] wdat,
    output logic [9:0] rdat
);
    logic [9:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdat;
    end

    // asynchronous read, as the LUTRAM primitive provides
    assign rdat = mem[addr];
endmodule

module lutram_array_bist #(
    parameter  int NUM_BANKS = 10,
    parameter  int DATA_W    = 10,
    localparam int DEPTH     = NUM_BANKS * 16,
    localparam int SLICES    = (DATA_W + 9) / 10,
    localparam int AW        = (DEPTH > 16) ? $clog2(DEPTH) : 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdat,
    input  logic              re,
    output logic [DATA_W-1:0] rdat,
    output logic              rvalid,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [AW-1:0]     bist_fail_addr
);
    localparam int PW = SLICES * 10;

    // shared array port, driven by the user or by the self-test
    logic [AW-1:0]                  ram_addr;
    logic                           ram_we;
    logic [DATA_W-1:0]              ram_wdat;
    logic                           user_re;
    wire  [DATA_W-1:0]              ram_rd;
    logic [DATA_W-1:0]              rd_mux;
    logic [PW-1:0]                  wpad;
    logic [AW-1:0]                  bank;
    logic                           in_range;
    logic [NUM_BANKS-1:0]           bank_we;
    logic [NUM_BANKS-1:0][PW-1:0]   bank_rd;
    logic                           unused_pad;

    assign bank     = ram_addr >> 4;
    assign in_range = {1'b0, ram_addr} < (AW+1)'(DEPTH);
    // bits above DATA_W in the top slice are always written as 0
    assign wpad     = PW'(ram_wdat);

    always_comb begin
        bank_we = '0;
        rd_mux  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (in_range && bank == AW'(b)) begin
                bank_we[b] = ram_we;
                rd_mux     = bank_rd[b][DATA_W-1:0];
            end
        end
    end

    // kept as a net so a bench can override the array read value
    assign ram_rd     = rd_mux;
    assign unused_pad = ^bank_rd;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar s = 0; s < SLICES; s++) begin : g_slice
            lutram_16x10 u_ram (
                .clk  (clk),
                .we   (bank_we[b]),
                .addr (ram_addr[3:0]),
                .wdat (wpad[s*10 +: 10]),
                .rdat (bank_rd[b][s*10 +: 10])
            );
        end
    end

    // registered read: captures pre-write data when we/re hit the same word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= user_re;
            if (user_re) rdat <= ram_rd;
        end
    end

`ifdef LUTRAM_BIST_EN
    typedef enum logic [2:0] {S_IDLE, S_W0, S_R0W1, S_R1W0, S_R0, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state, state_nx;
    logic [AW-1:0]     bcnt, bcnt_nx;
    logic              ph, ph_nx;       // 0: read cycle, 1: compare+write cycle
    logic              tail, tail_nx;   // extra cycle after the last R0 read
    logic              b_we, b_ones, chk_en, start_acc, busy;
    logic [DATA_W-1:0] exp_c;
    logic              chk_q;
    logic [DATA_W-1:0] rd_q, exp_q;
    logic [AW-1:0]     a_q;

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign start_acc = !busy && bist_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bcnt  <= '0;
            ph    <= 1'b0;
            tail  <= 1'b0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
            ph    <= ph_nx;
            tail  <= tail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        ph_nx    = ph;
        tail_nx  = tail;
        b_we     = 1'b0;
        b_ones   = 1'b0;
        chk_en   = 1'b0;
        exp_c    = '0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    state_nx = S_W0;
                    bcnt_nx  = '0;
                    ph_nx    = 1'b0;
                    tail_nx  = 1'b0;
                end
            end
            S_W0: begin
                b_we = 1'b1;
                if (bcnt == LAST) begin
                    state_nx = S_R0W1;
                    bcnt_nx  = '0;
                end else begin
                    bcnt_nx = bcnt + AW'(1);
                end
            end
            S_R0W1: begin
                chk_en = !ph;
                b_we   = ph;
                b_ones = 1'b1;
                ph_nx  = !ph;
                // leave bcnt at LAST: R1W0 walks down from there
                if (ph) begin
                    if (bcnt == LAST) state_nx = S_R1W0;
                    else              bcnt_nx  = bcnt + AW'(1);
                end
            end
            S_R1W0: begin
                chk_en = !ph;
                exp_c  = '1;
                b_we   = ph;
                ph_nx  = !ph;
                if (ph) begin
                    if (bcnt == '0) state_nx = S_R0;
                    else            bcnt_nx  = bcnt - AW'(1);
                end
            end
            S_R0: begin
                chk_en = !tail;
                if (tail)              state_nx = S_DONE;
                else if (bcnt == LAST) tail_nx  = 1'b1;
                else                   bcnt_nx  = bcnt + AW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // read data is captured one cycle, compared the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q          <= 1'b0;
            rd_q           <= '0;
            exp_q          <= '0;
            a_q            <= '0;
            bist_pass      <= 1'b0;
            bist_fail_addr <= '0;
        end else begin
            chk_q <= chk_en;
            if (chk_en) begin
                rd_q  <= ram_rd;
                exp_q <= exp_c;
                a_q   <= bcnt;
            end
            if (start_acc) begin
                bist_pass      <= 1'b1;
                bist_fail_addr <= '0;
            end else if (chk_q && rd_q != exp_q && bist_pass) begin
                bist_pass      <= 1'b0;
                bist_fail_addr <= a_q;
            end
        end
    end

    assign bist_busy = busy;
    assign bist_done = (state == S_DONE);
    assign ram_addr  = busy ? bcnt : addr;
    assign ram_we    = busy ? b_we : we;
    assign ram_wdat  = busy ? (b_ones ? '1 : '0) : wdat;
    assign user_re   = re && !busy;
`else
    logic unused_start;
    assign unused_start   = bist_start;
    assign bist_busy      = 1'b0;
    assign bist_done      = 1'b0;
    assign bist_pass      = 1'b0;
    assign bist_fail_addr = '0;
    assign ram_addr       = addr;
    assign ram_we         = we;
    assign ram_wdat       = wdat;
    assign user_re        = re;
`endif
endmodule

// File: tb/tb_lutram_array_bist.sv
// Bench for lutram_array_bist (NUM_BANKS=10, DATA_W=10). Directed corner
// cases, then random traffic scored against a word-array model. Self-test
// checks are built only when LUTRAM_BIST_EN is defined; otherwise the tied-off
// bist_* outputs and the always-live user port are checked.
module tb_lutram_array_bist;
    localparam int NB    = 10;
    localparam int DW    = 10;
    localparam int DEPTH = NB * 16;
    localparam int AW    = (DEPTH > 16) ? $clog2(DEPTH) : 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr;
    logic          we, re, bist_start;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          rvalid, bist_busy, bist_done, bist_pass;
    logic [AW-1:0] bist_fail_addr;

    int            n_vec = 0;
    int            n_err = 0;
    int            cnt;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_rd;
    logic          inj_en = 1'b0;

    always #5 clk = ~clk;

    lutram_array_bist #(.NUM_BANKS(NB), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .we             (we),
        .wdat           (wdat),
        .re             (re),
        .rdat           (rdat),
        .rvalid         (rvalid),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_pass      (bist_pass),
        .bist_fail_addr (bist_fail_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_rd(input int a);
        return (a < DEPTH) ? model[a] : '0;
    endfunction

    task automatic wr(input int a, input logic [DW-1:0] d);
        we = 1'b1; re = 1'b0; addr = AW'(a); wdat = d;
        step();
        we = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    task automatic rd(input int a, input string tag);
        re = 1'b1; we = 1'b0; addr = AW'(a);
        step();
        re = 1'b0;
        chk({tag, "_v"}, 32'(rvalid), 1);
        chk(tag, 32'(rdat), 32'(ref_rd(a)));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdat"},  32'(rdat), 0);
        chk({tag, "_rv"},    32'(rvalid), 0);
        chk({tag, "_busy"},  32'(bist_busy), 0);
        chk({tag, "_done"},  32'(bist_done), 0);
        chk({tag, "_pass"},  32'(bist_pass), 0);
        chk({tag, "_faddr"}, 32'(bist_fail_addr), 0);
    endtask

`ifdef LUTRAM_BIST_EN
    // stuck-at-1 on bit 0 of the bank-2 read word, seen only at row 5 (addr 37)
    initial forever begin
        @(negedge clk);
        if (inj_en && dut.ram_addr == AW'(37)) force dut.ram_rd = 10'h001;
        else release dut.ram_rd;
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        we = 1'b0; re = 1'b0; addr = '0; wdat = '0; bist_start = 1'b0;
        repeat (3) step();
        chk_idle("rst");
        rst_n = 1'b1;
        step();

        // basic write / read, single rvalid pulse, rdat hold
        wr(19, 10'h2A5);
        rd(19, "rd_13");
        step();
        chk("rv_pulse", 32'(rvalid), 0);
        chk("rd_hold", 32'(rdat), 10'h2A5);

        // read-before-write in the same cycle
        we = 1'b1; re = 1'b1; addr = AW'(19); wdat = 10'h155;
        step();
        we = 1'b0; re = 1'b0;
        model[19] = 10'h155;
        chk("rbw_old", 32'(rdat), 10'h2A5);
        chk("rbw_v", 32'(rvalid), 1);
        rd(19, "rbw_new");

        // range boundary
        wr(160, 10'h3FF);
        rd(160, "oor_rd");
        wr(159, 10'h3FF);
        rd(159, "top_rd");

        // async reset in mid-cycle with rvalid/rdat non-zero
        re = 1'b1; addr = AW'(159);
        step();
        re = 1'b0;
        chk("pre_arst", 32'(rdat), 10'h3FF);
        #2 rst_n = 1'b0;
        #1 chk_idle("arst");
        step();
        rst_n = 1'b1;

        // fill the array, then random traffic
        for (int a = 0; a < DEPTH; a++) wr(a, DW'($urandom));
        exp_rd = '0;
        for (int i = 0; i < 600; i++) begin
            int            a;
            logic          w, r;
            logic [DW-1:0] d;
            a = int'($urandom_range(DEPTH + 20, 0));
            w = 1'($urandom_range(1, 0));
            r = 1'($urandom_range(1, 0));
            d = DW'($urandom);
            we = w; re = r; addr = AW'(a); wdat = d;
            if (r) exp_rd = ref_rd(a);
            if (w && a < DEPTH) model[a] = d;
            step();
            chk("rnd_v", 32'(rvalid), 32'(r));
            chk("rnd_rd", 32'(rdat), 32'(exp_rd));
        end
        we = 1'b0; re = 1'b0;

`ifdef LUTRAM_BIST_EN
        // clean run: user traffic during the run must be ignored
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        we = 1'b1; re = 1'b1; addr = AW'(5); wdat = '1;
        cnt = 0;
        while (bist_busy && cnt < 2000) begin
            cnt++;
            chk("busy_rv", 32'(rvalid), 0);
            step();
        end
        we = 1'b0; re = 1'b0;
        chk("busy_len", 32'(cnt), 32'(6 * DEPTH + 1));
        chk("b_done", 32'(bist_done), 1);
        chk("b_pass", 32'(bist_pass), 1);
        chk("b_faddr", 32'(bist_fail_addr), 0);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        rd(159, "post_159");
        rd(5, "post_5");
        repeat (8) rd(int'($urandom_range(DEPTH - 1, 0)), "post_rnd");

        // faulty run
        inj_en = 1'b1;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        cnt = 0;
        while (bist_busy && cnt < 2000) begin
            cnt++;
            step();
        end
        inj_en = 1'b0;
        chk("f_len", 32'(cnt), 32'(6 * DEPTH + 1));
        chk("f_done", 32'(bist_done), 1);
        chk("f_pass", 32'(bist_pass), 0);
        chk("f_faddr", 32'(bist_fail_addr), 37);
        step();

        // rerun aborted by reset
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        chk("ab_busy", 32'(bist_busy), 1);
        chk("ab_done", 32'(bist_done), 0);
        chk("ab_pass", 32'(bist_pass), 1);
        chk("ab_faddr", 32'(bist_fail_addr), 0);
        repeat (99) step();
        #2 rst_n = 1'b0;
        #1 chk_idle("abort");
        step();
        rst_n = 1'b1;
        step();
        chk("ab_idle", 32'(bist_busy), 0);
`else
        // self-test absent: start is ignored, user port stays live
        for (int i = 0; i < 4; i++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            bist_start = 1'b1;
            rd(a, "nb_rd");
            chk("nb_busy", 32'(bist_busy), 0);
            chk("nb_done", 32'(bist_done), 0);
            chk("nb_pass", 32'(bist_pass), 0);
            chk("nb_faddr", 32'(bist_fail_addr), 0);
        end
        bist_start = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
